// File: rtl/display_ctrl_if.sv
// Value handshake between a producer and the seven-segment display controller.
interface display_ctrl_if;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/display_ctrl.sv
// 4-digit seven-segment controller: 14-bit binary -> BCD via double-dabble FSM,
// latched into display registers and time-multiplexed onto the segment bus.
module display_ctrl #(
  parameter int REFRESH_OVERFLOW = 2**19-1,
  parameter bit BLANK_LEADING    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  display_ctrl_if.slave     bus,
  output logic [3:0]        digit_select,
  output logic [6:0]        led_select
);
  localparam int            CW      = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW+1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_OVERFLOW);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  state_t          state;
  logic            rdy;
  logic [29:0]     sr;        // {bcd[15:0], bin[13:0]}
  logic [3:0]      iter;
  logic            ovf_pend;
  logic [3:0][3:0] disp_digit;
  logic            disp_ovf;
  logic [CW-1:0]   refresh_cnt;
  logic [1:0]      digit_idx;
  logic [15:0]     bcd_adj;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_adj
      assign bcd_adj[i*4 +: 4] = (sr[14+i*4 +: 4] >= 4'd5) ? sr[14+i*4 +: 4] + 4'd3
                                                           : sr[14+i*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdy        <= 1'b1;
      sr         <= '0;
      iter       <= '0;
      ovf_pend   <= 1'b0;
      disp_digit <= '0;
      disp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sr       <= {16'b0, bus.in_data};
          iter     <= '0;
          ovf_pend <= (bus.in_data > 14'd9999);
          rdy      <= 1'b0;
          state    <= CONVERT;
        end
        CONVERT: begin
          sr   <= {bcd_adj[14:0], sr[13:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd13) state <= LATCH;
        end
        LATCH: begin
          disp_digit <= sr[29:14];
          disp_ovf   <= ovf_pend;
          rdy        <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = rdy;

  // Scan runs free of the FSM so the old value stays lit during conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [3:0] cur;
  logic       blank;

  always_comb begin
    digit_select = ~(4'b0001 << digit_idx);
    cur          = disp_digit[digit_idx];
    blank        = BLANK_LEADING && (digit_idx != 2'd0);
    for (int i = 0; i < 4; i++)
      if (i >= int'(digit_idx) && disp_digit[i] != 4'd0) blank = 1'b0;
    if (disp_ovf)   led_select = SEG_DASH;
    else if (blank) led_select = SEG_BLANK;
    else            led_select = seg7(cur);
  end
endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench: stimulus pushes expected digit patterns, a negedge monitor
// pops them on each display update and checks every scanned digit.
module tb_display_ctrl;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111, SD = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ds1, ds0;
  logic [6:0] ls1, ls0;

  always #5 clk = ~clk;

  display_ctrl_if bus1 ();
  display_ctrl_if bus0 ();

  display_ctrl #(.REFRESH_OVERFLOW(3), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .digit_select(ds1), .led_select(ls1));
  display_ctrl #(.REFRESH_OVERFLOW(3), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .digit_select(ds0), .led_select(ls0));

  typedef struct {
    logic [3:0][6:0] seg;     // index 0 = ones digit, blanking enabled
    bit              is_rst;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] no_blank(input logic [6:0] s);
    return (s == SB) ? S0 : s;
  endfunction

  task automatic push(input logic [6:0] d3, d2, d1, d0, input bit r);
    exp_t e;
    e.seg    = {d3, d2, d1, d0};
    e.is_rst = r;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [13:0] d);
    bus1.in_valid = v; bus1.in_data = d;
    bus0.in_valid = v; bus0.in_data = d;
  endtask

  task automatic send(input logic [13:0] v);
    int n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus1.in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, 14'h2aaa);
  endtask

  // ---------------- monitor ----------------
  int   lowcnt = 0;
  int   scan_left = 0;
  bit   prev_rdy = 1'b1;
  bit   prev_rst = 1'b1;
  bit   scanning = 1'b0;
  exp_t cur;

  task automatic start_scan(input bit by_rst);
    if (q.size() == 0) begin
      errors++; checks++;
      $display("FAIL unexpected_update: got display change expected none at %0t", $time);
      scanning = 1'b0;
    end else begin
      cur = q.pop_front();
      chk("update_kind", 32'(by_rst), 32'(cur.is_rst));
      scanning  = 1'b1;
      scan_left = 16;
    end
  endtask

  always @(negedge clk) begin
    int idx;
    if (reset) begin
      lowcnt = 0; prev_rdy = 1'b1; prev_rst = 1'b1; scanning = 1'b0;
    end else begin
      if (prev_rst) begin
        start_scan(1'b1);
        chk("rst_ready", 32'(bus1.in_ready), 32'd1);
        chk("rst_digit_select", 32'(ds1), 32'hE);
      end else if (bus1.in_ready && !prev_rdy) begin
        chk("accept_latency", lowcnt, 15);
        start_scan(1'b0);
      end
      if (bus1.in_ready) lowcnt = 0; else lowcnt++;

      if (scanning) begin
        case (ds1)
          4'b1110: idx = 0;
          4'b1101: idx = 1;
          4'b1011: idx = 2;
          4'b0111: idx = 3;
          default: idx = -1;
        endcase
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL digit_select: got %b expected one-hot-low", ds1);
        end else begin
          if (cur.is_rst) chk("scan_order", idx, (16 - scan_left) / 4);
          chk($sformatf("seg_blank_d%0d", idx), 32'(ls1), 32'(cur.seg[idx]));
          chk($sformatf("seg_lit_d%0d", idx), 32'(ls0), 32'(no_blank(cur.seg[idx])));
          chk("digit_select_match", 32'(ds0), 32'(ds1));
        end
        scan_left--;
        if (scan_left == 0) scanning = 1'b0;
      end
      prev_rdy = bus1.in_ready;
      prev_rst = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, '0);
    push(SB, SB, SB, S0, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);

    push(S1, S2, S3, S4, 1'b0); send(14'd1234);  repeat (36) @(negedge clk);
    push(SB, SB, SB, S7, 1'b0); send(14'd7);     repeat (36) @(negedge clk);
    push(SB, SB, SB, S0, 1'b0); send(14'd0);     repeat (36) @(negedge clk);
    push(S9, S9, S9, S9, 1'b0); send(14'd9999);  repeat (36) @(negedge clk);
    push(SD, SD, SD, SD, 1'b0); send(14'd10000); repeat (36) @(negedge clk);
    push(SD, SD, SD, SD, 1'b0); send(14'd16383); repeat (36) @(negedge clk);
    push(SB, SB, SB, S5, 1'b0); send(14'd5);     repeat (36) @(negedge clk);

    // in_valid held high with fresh data each cycle: only k=0,16,32 are taken
    push(SB, SB, S4, S2, 1'b0);
    push(SB, S1, S0, S0, 1'b0);
    push(S3, S0, S0, S5, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_k%0d", k), 32'(bus1.in_ready), 32'((k % 16) == 0));
      case (k)
        0:       drive(1'b1, 14'd42);
        16:      drive(1'b1, 14'd100);
        32:      drive(1'b1, 14'd3005);
        default: drive(1'b1, 14'(8888 + k));
      endcase
    end
    @(negedge clk);
    drive(1'b0, '0);
    repeat (40) @(negedge clk);

    // reset mid-conversion: 4321 must never reach the display
    send(14'd4321);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    push(SB, SB, SB, S0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
